// File: rtl/key_scan_if.sv
// key_scan_if -- keypad-side signal bundle for key_scan.
//   row_in  [3:0] keypad rows, active-low, already synchronised
//   col_out [3:0] column drive, active-low, one-hot-low
//   keynum  [4:0] debounced key code, 0-15 held key, 16 = no key
//   pulse         one-cycle strobe on acceptance of a new press
// slave  : the scanner (drives columns, reports keys)
// master : the keypad / environment (drives rows)
interface key_scan_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [4:0] keynum;
  logic       pulse;

  modport master (output row_in, input col_out, input keynum, input pulse);
  modport slave  (input row_in, output col_out, output keynum, output pulse);
endinterface

// File: rtl/key_scan.sv
// key_scan -- 4x4 keypad column scanner with frame-based debounce.
//   clk    rising-edge system clock
//   reset  synchronous, active-high
//   kp     key_scan_if.slave: row_in in, col_out/keynum/pulse out
// Each column is driven low for SCAN_DIV cycles; rows are sampled on the
// last cycle of the slot. Four slots form a frame whose result is the lowest
// key code seen (16 if none). A press or release is accepted after
// DEB_FRAMES consistent frames.
module key_scan #(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned DEB_FRAMES = 4
) (
  input logic       clk,
  input logic       reset,
  key_scan_if.slave kp
);

  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  // One spare count so the increment in RELEASE cannot wrap when DEB_FRAMES=1.
  localparam int unsigned CW = $clog2(DEB_FRAMES + 2);
  localparam logic [4:0]  NO_KEY = 5'd16;

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_e;

  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    col_q, col_d;
  logic [4:0]    acc_q, acc_d;
  logic [4:0]    res_q, res_d;
  logic          fvalid_q, fvalid_d;
  state_e        state_q, state_d;
  logic [4:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    keynum_q, keynum_d;
  logic          pulse_q, pulse_d;

  logic          last_slot;
  logic [4:0]    slot_code;
  logic [4:0]    frame_min;
  logic [CW-1:0] cnt_inc;
  logic          reach;

  assign last_slot = (slot_q == SW'(SCAN_DIV - 1));

  // Lowest low row in the currently driven column.
  always_comb begin
    slot_code = NO_KEY;
    for (int unsigned r = 0; r < 4; r++) begin
      if (!kp.row_in[r] && slot_code == NO_KEY) begin
        slot_code = {1'b0, col_q, 2'(r)};
      end
    end
  end

  assign frame_min = (slot_code < acc_q) ? slot_code : acc_q;

  // Scan timing and per-frame accumulation.
  always_comb begin
    slot_d   = last_slot ? '0 : slot_q + 1'b1;
    col_d    = last_slot ? col_q + 2'd1 : col_q;
    acc_d    = acc_q;
    res_d    = res_q;
    fvalid_d = 1'b0;
    if (last_slot) begin
      if (col_q == 2'd3) begin
        res_d    = frame_min;
        fvalid_d = 1'b1;
        acc_d    = NO_KEY;
      end else begin
        acc_d = frame_min;
      end
    end
  end

  assign cnt_inc = cnt_q + 1'b1;
  assign reach   = (cnt_inc >= CW'(DEB_FRAMES));

  // Debounce FSM, evaluated once per frame when the frame result is fresh.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    keynum_d = keynum_q;
    pulse_d  = 1'b0;
    if (fvalid_q) begin
      case (state_q)
        IDLE: begin
          if (res_q != NO_KEY) begin
            cand_d  = res_q;
            cnt_d   = CW'(1);
            state_d = CONFIRM;
          end
        end
        CONFIRM: begin
          if (res_q == cand_q) begin
            if (reach) begin
              keynum_d = cand_q;
              pulse_d  = 1'b1;
              cnt_d    = '0;
              state_d  = HELD;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (res_q != NO_KEY) begin
            cand_d = res_q;
            cnt_d  = CW'(1);
          end else begin
            cand_d  = NO_KEY;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        HELD: begin
          if (res_q != cand_q) begin
            cnt_d   = CW'(1);
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (res_q == cand_q) begin
            cnt_d   = '0;
            state_d = HELD;
          end else if (reach) begin
            keynum_d = NO_KEY;
            cand_d   = NO_KEY;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q   <= '0;
      col_q    <= '0;
      acc_q    <= NO_KEY;
      res_q    <= NO_KEY;
      fvalid_q <= 1'b0;
      state_q  <= IDLE;
      cand_q   <= NO_KEY;
      cnt_q    <= '0;
      keynum_q <= NO_KEY;
      pulse_q  <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      col_q    <= col_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      fvalid_q <= fvalid_d;
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      keynum_q <= keynum_d;
      pulse_q  <= pulse_d;
    end
  end

  assign kp.col_out = ~(4'b0001 << col_q);
  assign kp.keynum  = keynum_q;
  assign kp.pulse   = pulse_q;

endmodule
